// File: rtl/fetch_aligner.sv
// Instruction alignment buffer: turns word-aligned 32-bit fetch words into a
// stream of whole 16/32-bit instructions with PCs, including redirect handling.
module fetch_aligner #(
    parameter logic [31:0] RESET_PC          = 32'h0000_0000,
    parameter int          INSTRUCTION_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fetch_valid,
    output logic                         fetch_ready,
    input  logic [INSTRUCTION_WIDTH-1:0] fetch_data,
    input  logic [31:0]                  fetch_pc,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_pc,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [31:0]                  instr_data,
    output logic                         instr_is_compressed,
    output logic [31:0]                  instr_pc
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_SEEK = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [2:0]  count_q, count_d;
    logic [63:0] buf_q, buf_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;

    logic [15:0] head_hw_s;
    logic        head_is_c_s;
    logic        pop_s;
    logic        push_s;
    logic [63:0] shifted_s;
    logic [2:0]  cnt_s;

    // Handshake qualifiers; everything here depends only on registered state
    always_comb begin
        head_hw_s   = buf_q[15:0];
        head_is_c_s = (head_hw_s[1:0] != 2'b11);
        if (state_q == ST_RUN) begin
            instr_valid = ((count_q >= 3'd1) && head_is_c_s) || (count_q >= 3'd2);
            fetch_ready = (count_q <= 3'd2);
        end else begin
            instr_valid = 1'b0;
            fetch_ready = 1'b1;
        end
        pop_s  = instr_valid && instr_ready;
        push_s = fetch_valid && fetch_ready;
    end

    // Output presentation; data is zeroed when nothing valid is held
    always_comb begin
        instr_pc = pc_q;
        if (instr_valid) begin
            instr_is_compressed = head_is_c_s;
            if (head_is_c_s) begin
                instr_data = {16'h0000, head_hw_s};
            end else begin
                instr_data = buf_q[31:0];
            end
        end else begin
            instr_is_compressed = 1'b0;
            instr_data          = 32'h0000_0000;
        end
    end

    // Next-state: redirect beats everything, then SEEK matching, then pop-then-push
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        buf_d     = buf_q;
        pc_d      = pc_q;
        target_d  = target_q;
        shifted_s = buf_q;
        cnt_s     = count_q;
        if (redirect_valid) begin
            state_d  = ST_SEEK;
            count_d  = 3'd0;
            target_d = redirect_pc & 32'hFFFF_FFFE;
            pc_d     = redirect_pc & 32'hFFFF_FFFE;
            buf_d    = 64'h0;
        end else if (state_q == ST_SEEK) begin
            if (push_s && (fetch_pc == {target_q[31:2], 2'b00})) begin
                state_d = ST_RUN;
                pc_d    = target_q;
                if (target_q[1]) begin
                    buf_d   = {48'h0, fetch_data[31:16]};
                    count_d = 3'd1;
                end else begin
                    buf_d   = {32'h0, fetch_data};
                    count_d = 3'd2;
                end
            end else begin
                count_d = 3'd0;
            end
        end else begin
            if (pop_s) begin
                if (head_is_c_s) begin
                    shifted_s = {16'h0000, buf_q[63:16]};
                    cnt_s     = count_q - 3'd1;
                    pc_d      = pc_q + 32'd2;
                end else begin
                    shifted_s = {32'h0000_0000, buf_q[63:32]};
                    cnt_s     = count_q - 3'd2;
                    pc_d      = pc_q + 32'd4;
                end
            end else begin
                pc_d = pc_q;
            end
            // push is only possible with count <= 2, so the word fits in slots 0..3
            if (push_s) begin
                case (cnt_s[1:0])
                    2'd0:    shifted_s[31:0]  = fetch_data;
                    2'd1:    shifted_s[47:16] = fetch_data;
                    2'd2:    shifted_s[63:32] = fetch_data;
                    default: shifted_s        = shifted_s;
                endcase
                cnt_s = cnt_s + 3'd2;
            end else begin
                cnt_s = cnt_s;
            end
            buf_d   = shifted_s;
            count_d = cnt_s;
        end
    end

    // State registers; reset acts as a redirect to RESET_PC
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_SEEK;
            count_q  <= 3'd0;
            buf_q    <= 64'h0;
            pc_q     <= RESET_PC;
            target_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            buf_q    <= buf_d;
            pc_q     <= pc_d;
            target_q <= target_d;
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed table-driven bench for fetch_aligner plus hand-written reset and
// mid-operation reset sequences.
module tb_fetch_aligner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [31:0] fetch_data = 32'h0;
    logic [31:0] fetch_pc = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic        instr_is_compressed;
    logic [31:0] instr_pc;

    int checks = 0;
    int errors = 0;

    fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .fetch_valid         (fetch_valid),
        .fetch_ready         (fetch_ready),
        .fetch_data          (fetch_data),
        .fetch_pc            (fetch_pc),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .instr_valid         (instr_valid),
        .instr_ready         (instr_ready),
        .instr_data          (instr_data),
        .instr_is_compressed (instr_is_compressed),
        .instr_pc            (instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        fv;
        logic [31:0] fd;
        logic [31:0] fp;
        logic        ir;
        logic        e_fr;
        logic        e_iv;
        logic [31:0] e_d;
        logic [31:0] e_pc;
        logic        e_c;
    } vec_t;

    vec_t vecs[64];
    int   nvec = 0;

    task automatic add(input logic rv, input logic [31:0] rpc, input logic fv,
                       input logic [31:0] fd, input logic [31:0] fp, input logic ir,
                       input logic e_fr, input logic e_iv, input logic [31:0] e_d,
                       input logic [31:0] e_pc, input logic e_c);
        vecs[nvec] = '{rv, rpc, fv, fd, fp, ir, e_fr, e_iv, e_d, e_pc, e_c};
        nvec++;
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [step %0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_outs(input int idx, input logic e_fr, input logic e_iv,
                              input logic [31:0] e_d, input logic [31:0] e_pc,
                              input logic e_c);
        check("fetch_ready", idx, {31'b0, fetch_ready}, {31'b0, e_fr});
        check("instr_valid", idx, {31'b0, instr_valid}, {31'b0, e_iv});
        if (e_iv) begin
            check("instr_data", idx, instr_data, e_d);
            check("instr_pc", idx, instr_pc, e_pc);
            check("instr_is_compressed", idx, {31'b0, instr_is_compressed}, {31'b0, e_c});
        end
    endtask

    task automatic drive(input logic rv, input logic [31:0] rpc, input logic fv,
                         input logic [31:0] fd, input logic [31:0] fp, input logic ir);
        redirect_valid = rv;
        redirect_pc    = rpc;
        fetch_valid    = fv;
        fetch_data     = fd;
        fetch_pc       = fp;
        instr_ready    = ir;
    endtask

    initial begin
        // rv rpc fv fd fp ir | fr iv data pc c
        // aligned 32-bit stream
        add(0, 0, 1, 32'h00500093, 32'h0, 1,   1, 0, 0, 0, 0);
        add(0, 0, 1, 32'h00A00113, 32'h4, 1,   1, 1, 32'h00500093, 32'h0, 0);
        add(0, 0, 0, 0, 0, 1,                  1, 1, 32'h00A00113, 32'h4, 0);
        // compressed pair, buffer filled to 4 by a stalled cycle
        add(1, 32'h0, 0, 0, 0, 1,              1, 0, 0, 0, 0);
        add(0, 0, 1, 32'h45014505, 32'h0, 1,   1, 0, 0, 0, 0);
        add(0, 0, 1, 32'h00A00113, 32'h4, 0,   1, 1, 32'h00004505, 32'h0, 1);
        add(0, 0, 0, 0, 0, 1,                  0, 1, 32'h00004505, 32'h0, 1);
        add(0, 0, 0, 0, 0, 1,                  0, 1, 32'h00004501, 32'h2, 1);
        add(0, 0, 0, 0, 0, 1,                  1, 1, 32'h00A00113, 32'h4, 0);
        // straddling 32-bit instruction
        add(1, 32'h0, 0, 0, 0, 1,              1, 0, 0, 0, 0);
        add(0, 0, 1, 32'h00934505, 32'h0, 1,   1, 0, 0, 0, 0);
        add(0, 0, 1, 32'h01130050, 32'h4, 1,   1, 1, 32'h00004505, 32'h0, 1);
        add(0, 0, 0, 0, 0, 1,                  0, 1, 32'h00500093, 32'h2, 0);
        add(0, 0, 1, 32'h458100A0, 32'h8, 1,   1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1,                  0, 1, 32'h00A00113, 32'h6, 0);
        add(0, 0, 0, 0, 0, 1,                  1, 1, 32'h00004581, 32'hA, 1);
        // redirect to odd halfword with 3 halfwords buffered (bit 0 of target set)
        add(0, 0, 1, 32'h45014505, 32'hC, 0,   1, 0, 0, 0, 0);
        add(0, 0, 1, 32'h00934505, 32'h10, 1,  1, 1, 32'h00004505, 32'hC, 1);
        add(1, 32'h103, 0, 0, 0, 1,            0, 1, 32'h00004501, 32'hE, 1);
        add(0, 0, 1, 32'h12345678, 32'hF8, 1,  1, 0, 0, 0, 0);
        add(0, 0, 1, 32'hDEADBEEF, 32'hFC, 1,  1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1,                  1, 0, 0, 0, 0);
        add(0, 0, 1, 32'h00934505, 32'h100, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 32'h45810050, 32'h104, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1,                  0, 1, 32'h00500093, 32'h102, 0);
        add(0, 0, 0, 0, 0, 1,                  1, 1, 32'h00004581, 32'h106, 1);
        // 5-cycle decode stall with compressed head
        add(0, 0, 1, 32'h45014505, 32'h108, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 32'h00A00113, 32'h10C, 0, 1, 1, 32'h00004505, 32'h108, 1);
        for (int k = 0; k < 4; k++)
            add(0, 0, 1, 32'h00500093, 32'h110, 0, 0, 1, 32'h00004505, 32'h108, 1);
        add(0, 0, 1, 32'h00500093, 32'h110, 1, 0, 1, 32'h00004505, 32'h108, 1);
        add(0, 0, 1, 32'h00500093, 32'h110, 1, 0, 1, 32'h00004501, 32'h10A, 1);
        add(0, 0, 1, 32'h00500093, 32'h110, 1, 1, 1, 32'h00A00113, 32'h10C, 0);
        add(0, 0, 0, 0, 0, 1,                  1, 1, 32'h00500093, 32'h110, 0);
        // PC wrap at top of address space
        add(1, 32'hFFFFFFFC, 0, 0, 0, 1,       1, 0, 0, 0, 0);
        add(0, 0, 1, 32'h45014505, 32'hFFFFFFFC, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 32'h00500093, 32'h0, 1,   1, 1, 32'h00004505, 32'hFFFFFFFC, 1);
        add(0, 0, 0, 0, 0, 1,                  0, 1, 32'h00004501, 32'hFFFFFFFE, 1);
        add(0, 0, 0, 0, 0, 1,                  1, 1, 32'h00500093, 32'h0, 0);
        // back-to-back redirects, last wins; fetch in redirect cycle dropped
        add(1, 32'h200, 0, 0, 0, 1,            1, 0, 0, 0, 0);
        add(1, 32'h300, 1, 32'h00A00113, 32'h200, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 32'h00A00113, 32'h200, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 32'h00500093, 32'h300, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1,                  1, 1, 32'h00500093, 32'h300, 0);
        add(0, 0, 0, 0, 0, 1,                  1, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset instr_valid", -1, {31'b0, instr_valid}, 32'h0);
        check("reset fetch_ready", -1, {31'b0, fetch_ready}, 32'h1);
        check("reset instr_pc", -1, instr_pc, 32'h0);
        check("reset instr_data", -1, instr_data, 32'h0);
        check("reset instr_is_compressed", -1, {31'b0, instr_is_compressed}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < nvec; i++) begin
            drive(vecs[i].rv, vecs[i].rpc, vecs[i].fv, vecs[i].fd, vecs[i].fp, vecs[i].ir);
            check_outs(i, vecs[i].e_fr, vecs[i].e_iv, vecs[i].e_d, vecs[i].e_pc, vecs[i].e_c);
            @(negedge clk);
        end

        // mid-operation reset with count = 3 and a valid head; redirect also raised
        drive(0, 0, 1, 32'h45014505, 32'h304, 0);
        @(negedge clk);
        drive(0, 0, 1, 32'h00934505, 32'h308, 1);
        check_outs(100, 1'b1, 1'b1, 32'h00004505, 32'h304, 1'b1);
        @(negedge clk);
        check_outs(101, 1'b0, 1'b1, 32'h00004501, 32'h306, 1'b1);
        drive(1, 32'h400, 0, 0, 0, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 1, 32'h00A00113, 32'h0, 1);
        check("rst instr_valid", 102, {31'b0, instr_valid}, 32'h0);
        check("rst instr_pc", 102, instr_pc, 32'h0);
        check("rst fetch_ready", 102, {31'b0, fetch_ready}, 32'h1);
        check("rst instr_data", 102, instr_data, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1);
        check_outs(103, 1'b1, 1'b1, 32'h00A00113, 32'h0, 1'b0);
        @(negedge clk);
        check_outs(104, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
